pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register. Generic successor to the fixed-field stage registers between MEM/WB and the other stages.
- Carries an opaque payload (DATA_W) plus PC (PC_W) under a valid/ready handshake.
- Supports stall, flush, an optional 2-entry skid buffer that registers up_ready, and saturating performance counters.
- Sits between any two pipeline stages of the MiniMIPS32s core.

Parameters:
- DATA_W, 107: payload width (packed stage fields).
- PC_W, 32: PC width carried alongside the payload for exception reporting.
- SKID, 1: 1 = 2-entry skid buffer with registered up_ready; 0 = single entry with combinational up_ready.
- ZERO_INVALID, 1: 1 = down_data/down_pc read all-zero whenever down_valid=0; 0 = stale values held.
- CNT_W, 16: width of the performance counters.

Ports:
- cpu_clk_50M  in  1  clock.
- cpu_rst_n  in  1  asynchronous active-low reset.
- up_valid  in  1  upstream holds a valid entry.
- up_ready  out  1  stage can accept an entry.
- up_data  in  DATA_W  upstream payload.
- up_pc  in  PC_W  upstream PC.
- down_valid  out  1  stage presents a valid entry.
- down_ready  in  1  downstream accepts.
- down_data  out  DATA_W  presented payload.
- down_pc  out  PC_W  presented PC.
- stall  in  1  freeze the stage (no transfer in or out).
- flush  in  1  discard all held entries.
- bubble_cnt  out  CNT_W  count of non-stalled cycles with no valid output.
- drop_cnt  out  CNT_W  count of entries discarded by flush.

Behaviour:
- Reset (async, cpu_rst_n=0):
  - State EMPTY; both entries invalid; main and skid data/PC = 0.
  - Counters = 0; down_valid=0; down_data=0; down_pc=0.
  - up_ready = 0 while in reset.
- Fire conditions:
  - up_fire = up_valid & up_ready.
  - down_fire = down_valid & down_ready.
- Output gating:
  - down_valid = main_valid & ~stall & ~flush.
  - up_ready = ~stall & ~flush & cond.
    - SKID=1: cond = ~skid_valid (registered).
    - SKID=0: cond = ~main_valid | down_ready (combinational).
- States (SKID=1): EMPTY, ONE (main valid), TWO (main+skid valid).
  - EMPTY: up_fire -> ONE, main <= up.
  - ONE:
    - up_fire & down_fire -> ONE, main <= up.
    - up_fire & ~down_fire -> TWO, skid <= up.
    - ~up_fire & down_fire -> EMPTY.
    - Otherwise hold.
  - TWO: down_fire -> ONE, main <= skid. No up_fire is possible (up_ready=0).
  - TWO is unreachable when SKID=0.
- Latency and ordering:
  - 1 cycle from up_fire to down_valid.
  - Strict FIFO order.
  - No combinational path from up_* to down_*.
- Stall: no state, data or counter change except bubble_cnt, which does not count stalled cycles. Entries are held indefinitely.
- Flush (synchronous):
  - Priority: below reset, above stall and handshake.
  - Next state EMPTY.
  - drop_cnt += number of valid entries (0/1/2), saturating.
  - An incoming entry in the same cycle is not accepted (up_ready=0).
  - Held data: zeroed if ZERO_INVALID=1, else kept.
- Stall+flush in the same cycle: the flush wins.
- bubble_cnt: +1 on every cycle where ~stall & ~flush & ~main_valid. Saturates at all-ones, no wrap.
- ZERO_INVALID=1: down_data and down_pc are forced to 0 whenever down_valid=0, including during stall.
- Reset mid-TWO: both entries are lost immediately. Not counted in drop_cnt.

Test Plan:
- Reset then idle 5 cycles -> down_valid=0, down_data=0, up_ready=1 after release, bubble_cnt=5.
- Stream A=0x11 (pc 0x100), B=0x22 (pc 0x104) with down_ready=1 -> each appears 1 cycle after its up_fire, in order, with matching PC.
- SKID=1: down_ready=0, push A,B,C -> A,B accepted, up_ready=0 from the cycle after B; raise down_ready -> A, B, C delivered in order, no loss or duplication.
- Stall=1 for 3 cycles with state ONE holding 0x33 -> down_valid=0, up_ready=0, bubble_cnt unchanged; stall=0 -> 0x33 presented unchanged.
- State TWO, pulse flush with up_valid=1 -> next cycle EMPTY, drop_cnt=2, up entry not accepted, down_data=0 (ZERO_INVALID=1).
- CNT_W=4, 20 empty non-stalled cycles -> bubble_cnt holds 15. Assert cpu_rst_n=0 asynchronously mid-cycle -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: payload + PC under valid/ready, with stall,
// flush, optional 2-entry skid buffer and saturating bubble/drop counters.
module pipe_stage_reg #(
  parameter int DATA_W       = 107,
  parameter int PC_W         = 32,
  parameter int SKID         = 1,
  parameter int ZERO_INVALID = 1,
  parameter int CNT_W        = 16
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [PC_W-1:0]   up_pc,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [DATA_W-1:0] down_data,
  output logic [PC_W-1:0]   down_pc,
  input  logic              stall,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             state_r;
  logic [DATA_W-1:0]  main_data_r;
  logic [DATA_W-1:0]  skid_data_r;
  logic [PC_W-1:0]    main_pc_r;
  logic [PC_W-1:0]    skid_pc_r;
  logic [CNT_W-1:0]   bubble_cnt_r;
  logic [CNT_W-1:0]   drop_cnt_r;

  logic               main_valid_s;
  logic               skid_valid_s;
  logic               cond_s;
  logic               up_ready_s;
  logic               down_valid_s;
  logic               up_fire_s;
  logic               down_fire_s;
  logic [DATA_W-1:0]  down_data_s;
  logic [PC_W-1:0]    down_pc_s;
  logic [1:0]         drop_amt_s;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0] amt);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, amt};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  // Handshake gating and output masking; up_ready is also forced low in reset.
  always_comb begin
    main_valid_s = (state_r != ST_EMPTY);
    skid_valid_s = (state_r == ST_TWO);
    if (SKID != 0) begin
      cond_s = ~skid_valid_s;
    end else begin
      cond_s = ~main_valid_s | down_ready;
    end
    up_ready_s   = cpu_rst_n & ~stall & ~flush & cond_s;
    down_valid_s = main_valid_s & ~stall & ~flush;
    up_fire_s    = up_valid & up_ready_s;
    down_fire_s  = down_valid_s & down_ready;
    drop_amt_s   = {skid_valid_s, main_valid_s & ~skid_valid_s};
    if ((ZERO_INVALID != 0) && !down_valid_s) begin
      down_data_s = '0;
      down_pc_s   = '0;
    end else begin
      down_data_s = main_data_r;
      down_pc_s   = main_pc_r;
    end
  end

  // Stage state machine, entry storage and performance counters.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_r      <= ST_EMPTY;
      main_data_r  <= '0;
      main_pc_r    <= '0;
      skid_data_r  <= '0;
      skid_pc_r    <= '0;
      bubble_cnt_r <= '0;
      drop_cnt_r   <= '0;
    end else if (flush) begin
      state_r    <= ST_EMPTY;
      drop_cnt_r <= sat_add(drop_cnt_r, drop_amt_s);
      if (ZERO_INVALID != 0) begin
        main_data_r <= '0;
        main_pc_r   <= '0;
        skid_data_r <= '0;
        skid_pc_r   <= '0;
      end
    end else if (!stall) begin
      if (!main_valid_s) begin
        bubble_cnt_r <= sat_add(bubble_cnt_r, 2'd1);
      end
      case (state_r)
        ST_EMPTY: begin
          if (up_fire_s) begin
            state_r     <= ST_ONE;
            main_data_r <= up_data;
            main_pc_r   <= up_pc;
          end
        end
        ST_ONE: begin
          if (up_fire_s && down_fire_s) begin
            main_data_r <= up_data;
            main_pc_r   <= up_pc;
          end else if (up_fire_s && (SKID != 0)) begin
            state_r     <= ST_TWO;
            skid_data_r <= up_data;
            skid_pc_r   <= up_pc;
          end else if (!up_fire_s && down_fire_s) begin
            state_r <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // up_ready is low here, so only the drain path matters.
          if (down_fire_s) begin
            state_r     <= ST_ONE;
            main_data_r <= skid_data_r;
            main_pc_r   <= skid_pc_r;
          end
        end
        default: state_r <= ST_EMPTY;
      endcase
    end
  end

  assign up_ready   = up_ready_s;
  assign down_valid = down_valid_s;
  assign down_data  = down_data_s;
  assign down_pc    = down_pc_s;
  assign bubble_cnt = bubble_cnt_r;
  assign drop_cnt   = drop_cnt_r;

endmodule
